// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch sequencer state (FETCH / HALTED / ERROR)
//   fetch_entry_t : one fetch queue entry, {pc, instr}
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    ERROR  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   flush_i     : drop all entries; wins over push_i/pop_i
//   push_i      : write wdata_i (taken when not full, or when popping)
//   pop_i       : remove head (ignored when empty)
//   wdata_i     : entry to write
//   rdata_o     : head entry (registered storage, never X after reset)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full queue is allowed only when the head leaves on the
  // same edge; the count then stays at DEPTH.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the PC, addresses the combinational instruction
// memory, queues {pc, instr} and hands entries to decode.
// Handshake: an entry transfers on a rising edge where if_valid and
// if_ready are both 1; if_valid never depends on if_ready.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   imem_addr         : byte address to instruction memory (= pc)
//   imem_rdata        : instruction word for imem_addr, same cycle
//   if_valid/if_ready : queue-head handshake to decode
//   if_instr/if_pc    : queue-head instruction and its PC
//   redirect_valid/pc : flush and restart fetch at redirect_pc
//   halt              : level; suspends new fetches
//   misalign_err      : sticky, set by a misaligned redirect target
//   state_dbg_o       : current sequencer state, for observation
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_rdata,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         halt,
  output logic         misalign_err,
  output fetch_state_t state_dbg_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         err_q, err_d;
  logic         q_full, q_empty;
  logic         push, pop, redir_bad;
  fetch_entry_t q_head, q_wdata;

  assign imem_addr    = pc_q;
  assign misalign_err = err_q;
  assign state_dbg_o  = state_q;
  assign if_valid     = !q_empty;
  assign if_instr     = q_head.instr;
  assign if_pc        = q_head.pc;

  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign pop       = if_valid && if_ready;
  // A redirect edge never pushes: the word at the old pc is on the wrong path.
  assign push      = (state_q == FETCH) && !halt && !redirect_valid &&
                     (!q_full || pop);
  assign q_wdata   = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    unique case (state_q)
      FETCH:   if (halt)  state_d = HALTED;
      HALTED:  if (!halt) state_d = FETCH;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
    if (redir_bad) begin
      // pc is left untouched so the faulting fetch point stays visible.
      state_d = ERROR;
      err_d   = 1'b1;
    end else if (redirect_valid && state_q != ERROR) begin
      // Also taken while HALTED: resume then starts at the new target.
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         if_valid;
  logic         if_ready;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         halt;
  logic         misalign_err;
  fetch_state_t state_dbg;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .misalign_err   (misalign_err),
    .state_dbg_o    (state_dbg)
  );

  // Instruction memory: word i holds 32'h1000_0000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected queue of {pc, instr} words, the architectural pc, mode, error.
  logic [63:0]  exp_q[$];
  logic [31:0]  m_pc   = 32'h0;
  fetch_state_t m_mode = FETCH;
  logic         m_err  = 1'b0;

  task automatic model_edge(input logic r_n, input logic rdy, input logic rv,
                            input logic [31:0] rpc, input logic h);
    bit popping, pushing;
    popping = (exp_q.size() != 0) && rdy;
    if (!r_n) begin
      exp_q.delete();
      m_pc = 32'h0; m_mode = FETCH; m_err = 1'b0;
      return;
    end
    if (rv) begin
      exp_q.delete();
      if (rpc[1:0] != 2'b00) begin
        m_err = 1'b1; m_mode = ERROR;
        return;
      end
      if (m_mode == ERROR) return;
      m_pc = rpc;
    end else begin
      pushing = (m_mode == FETCH) && !h &&
                ((exp_q.size() < DEPTH) || popping);
      if (popping) void'(exp_q.pop_front());
      if (pushing) begin
        exp_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_mode == FETCH && h) m_mode = HALTED;
    else if (m_mode == HALTED && !h) m_mode = FETCH;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r_n, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic h);
    logic [63:0] head;
    rst_n = r_n; if_ready = rdy; redirect_valid = rv;
    redirect_pc = rpc; halt = h;
    @(posedge clk);
    model_edge(r_n, rdy, rv, rpc, h);
    #1;
    check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
    check("imem_addr", imem_addr, m_pc);
    check("misalign_err", 32'(misalign_err), 32'(m_err));
    check("state", 32'(state_dbg), 32'(m_mode));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("if_pc", if_pc, head[63:32]);
      check("if_instr", if_instr, head[31:0]);
    end
    if (!r_n) begin
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
    end
  endtask

  task automatic idle(input int n, input logic rdy, input logic h);
    for (int i = 0; i < n; i++) cycle(1'b1, rdy, 1'b0, 32'h0, h);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_h;
    logic        r_rv;
    logic [31:0] r_pc;

    // 1: streaming from reset, no bubbles
    do_reset();
    idle(6, 1'b1, 1'b0);

    // 2: decode stalled from reset, then drain in order
    do_reset();
    idle(5, 1'b0, 1'b0);
    idle(6, 1'b1, 1'b0);

    // 3: redirect while full
    do_reset();
    idle(3, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    idle(5, 1'b1, 1'b0);

    // 4: misaligned redirect is sticky until reset
    cycle(1'b1, 1'b1, 1'b1, 32'h42, 1'b0);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0,
            1'($urandom_range(0, 1)));
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(4, 1'b1, 1'b0);

    // 5: halt with decode ready, queue drains, resume at held pc
    do_reset();
    idle(3, 1'b1, 1'b0);
    idle(5, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b0);

    // 6: redirect and halt on the same edge
    cycle(1'b1, 1'b0, 1'b1, 32'h20, 1'b1);
    idle(3, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b0);

    // pc wrap at the top of the address space
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF4, 1'b0);
    idle(6, 1'b1, 1'b0);

    // randomized traffic
    r_h = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 14) == 0) r_h = ~r_h;
      r_rv = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0:       r_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
        1:       r_pc = $urandom | 32'h1;
        default: r_pc = {$urandom_range(0, 255), 2'b00};
      endcase
      // once in error only misaligned redirects are issued
      if (m_err && r_pc[1:0] == 2'b00) r_rv = 1'b0;
      if ($urandom_range(0, 199) == 0)
        cycle(1'b0, 1'($urandom_range(0, 1)), r_rv, r_pc, r_h);
      else
        cycle(1'b1, 1'($urandom_range(0, 3) != 0), r_rv, r_pc, r_h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
